// File: rtl/rr_lock_arb.sv
// rr_lock_arb: packet-locking fixed/round-robin arbiter; req/eop/ack in, registered one-hot grt with grt_idx/grt_vld, combinational xfer out
module rr_lock_arb #(
  parameter int PORTS   = 5,
  parameter int IDXW    = 3,
  parameter int RR_MODE = 1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [PORTS-1:0] req,
  input  logic [PORTS-1:0] eop,
  input  logic             ack,
  output logic [PORTS-1:0] grt,
  output logic [IDXW-1:0]  grt_idx,
  output logic             grt_vld,
  output logic             xfer
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [PORTS-1:0] grt_q, grt_d;
  logic [IDXW-1:0]  idx_q, idx_d, ptr_q, ptr_d, win;
  logic             found, start, rel;
  int               j;
  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < PORTS; i++) begin
      j = (RR_MODE != 0) ? int'(ptr_q) + i : i;
      if (j >= PORTS) j = j - PORTS;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = IDXW'(j);
      end
    end
  end
  assign xfer  = |(req & grt_q) & ack;
  assign rel   = xfer & |(eop & grt_q);
  assign start = (state_q == IDLE) & |req;
  always_comb begin
    state_d = start ? BUSY : rel ? IDLE : state_q;
    grt_d   = start ? PORTS'(1) << win : rel ? '0 : grt_q;
    idx_d   = start ? win : idx_q;
    ptr_d   = (rel && RR_MODE != 0) ? ((idx_q == IDXW'(PORTS-1)) ? '0 : idx_q + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q <= IDLE;
      grt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grt_q   <= grt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end
  assign grt     = grt_q;
  assign grt_idx = idx_q;
  assign grt_vld = (state_q == BUSY);
  assert property (@(posedge clk) disable iff (rst_) $onehot0(grt_q));
  assert property (@(posedge clk) disable iff (rst_) grt_vld == |grt_q);
  assert property (@(posedge clk) disable iff (rst_) (state_q == BUSY && !rel) |=> grt_q == $past(grt_q));
endmodule

// File: tb/tb_rr_lock_arb.sv
// tb_rr_lock_arb: directed bench comparing fixed-priority and round-robin arbiters against a packet-level model
module tb_rr_lock_arb;
  localparam int P = 5;
  logic clk = 1'b0, rst_ = 1'b1, ack = 1'b0, en = 1'b0;
  logic [P-1:0] req = '0, eop = '0;
  logic [P-1:0] fp_grt, rr_grt;
  logic [2:0]   fp_idx, rr_idx;
  logic         fp_vld, rr_vld, fp_xfer, rr_xfer;
  int chks = 0, errs = 0;
  int own [2] = '{-1, -1};
  int mptr [2] = '{0, 0};
  always #5 clk = ~clk;
  rr_lock_arb #(.PORTS(P), .IDXW(3), .RR_MODE(0)) fp (.clk(clk), .rst_(rst_), .req(req), .eop(eop), .ack(ack),
    .grt(fp_grt), .grt_idx(fp_idx), .grt_vld(fp_vld), .xfer(fp_xfer));
  rr_lock_arb #(.PORTS(P), .IDXW(3), .RR_MODE(1)) rr (.clk(clk), .rst_(rst_), .req(req), .eop(eop), .ack(ack),
    .grt(rr_grt), .grt_idx(rr_idx), .grt_vld(rr_vld), .xfer(rr_xfer));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    chks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic int pick(input int m, input logic [P-1:0] rq, input int p);
    for (int k = 0; k < P; k++) begin
      int n;
      n = (m != 0) ? (p + k) % P : k;
      if (rq[n]) return n;
    end
    return -1;
  endfunction
  always @(posedge clk)
    for (int m = 0; m < 2; m++) begin
      if (rst_) begin
        own[m]  = -1;
        mptr[m] = 0;
      end else if (own[m] < 0) begin
        own[m] = pick(m, req, mptr[m]);
      end else if (req[own[m]] && ack && eop[own[m]]) begin
        if (m == 1) mptr[m] = (own[m] + 1) % P;
        own[m] = -1;
      end
    end
  task automatic cmp(input int m, input logic [P-1:0] g, input logic [2:0] ix, input logic v, input logic x);
    logic [P-1:0] eg;
    string s;
    s  = (m != 0) ? "rr" : "fp";
    eg = (own[m] < 0) ? '0 : P'(1) << own[m];
    chk({s, "_model_grt"}, g, eg);
    chk({s, "_model_vld"}, v, own[m] >= 0);
    chk({s, "_model_xfer"}, x, own[m] >= 0 && req[own[m]] && ack);
    if (own[m] >= 0) chk({s, "_model_idx"}, ix, own[m]);
  endtask
  always @(negedge clk)
    if (en) begin
      cmp(0, fp_grt, fp_idx, fp_vld, fp_xfer);
      cmp(1, rr_grt, rr_idx, rr_vld, rr_xfer);
    end
  task automatic drive(input logic r, input logic [P-1:0] rq, input logic [P-1:0] e, input logic a);
    rst_ = r;
    req  = rq;
    eop  = e;
    ack  = a;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic step(input logic r, input logic [P-1:0] rq, input logic [P-1:0] e, input logic a);
    drive(r, rq, e, a);
    tick();
  endtask
  initial begin
    step(1, 5'b10110, 0, 0);
    step(1, 5'b10110, 0, 0);
    en = 1'b1;
    chk("rst_grt", rr_grt, 0);
    chk("rst_vld", rr_vld, 0);
    chk("rst_idx", rr_idx, 0);
    chk("rst_fp_grt", fp_grt, 0);
    step(0, 5'b10110, 0, 0);
    chk("first_grt", rr_grt, 5'b00010);
    chk("first_idx", rr_idx, 1);
    chk("first_fp_grt", fp_grt, 5'b00010);
    step(0, 5'b10110, 5'b00010, 1);
    chk("first_rel", rr_grt, 0);
    step(0, 0, 0, 0);
    step(0, 5'b00100, 0, 0);
    chk("lock_grant", rr_grt, 5'b00100);
    step(0, 5'b00100, 0, 1);
    chk("lock_c1", rr_grt, 5'b00100);
    step(0, 5'b00101, 0, 0);
    chk("lock_c2", rr_grt, 5'b00100);
    step(0, 5'b00101, 0, 1);
    chk("lock_c3", rr_grt, 5'b00100);
    step(0, 5'b00101, 0, 1);
    chk("lock_c4", rr_grt, 5'b00100);
    chk("lock_fp_c4", fp_grt, 5'b00100);
    step(0, 5'b00101, 5'b00100, 1);
    chk("lock_bubble", rr_grt, 0);
    step(0, 5'b00001, 0, 0);
    chk("lock_next", rr_grt, 5'b00001);
    chk("lock_fp_next", fp_grt, 5'b00001);
    step(0, 5'b00001, 5'b00001, 1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      step(0, 5'b11111, 5'b11111, 1);
      if (k % 2 == 0) begin
        chk("rr_seq_idx", rr_idx, (k / 2) % P);
        chk("rr_seq_vld", rr_vld, 1);
        chk("fp_seq_idx", fp_idx, 0);
      end else begin
        chk("rr_seq_idle", rr_vld, 0);
      end
      chk("fp_not4", fp_grt[4], 0);
    end
    step(0, 5'b01000, 0, 0);
    chk("bub_grant", rr_grt, 5'b01000);
    step(0, 5'b01010, 0, 1);
    chk("bub_flit", rr_grt, 5'b01000);
    for (int k = 0; k < 3; k++) begin
      drive(0, 5'b00010, 0, 1);
      chk("bub_xfer", rr_xfer, 0);
      chk("bub_fp_xfer", fp_xfer, 0);
      tick();
      chk("bub_hold", rr_grt, 5'b01000);
    end
    step(0, 5'b01010, 5'b01000, 1);
    chk("bub_rel", rr_grt, 0);
    step(0, 5'b00010, 0, 0);
    chk("bub_next", rr_grt, 5'b00010);
    chk("bub_fp_next", fp_grt, 5'b00010);
    step(0, 5'b00010, 5'b00010, 1);
    step(0, 0, 0, 0);
    step(0, 5'b10000, 0, 0);
    chk("mrst_grant", rr_grt, 5'b10000);
    step(0, 5'b10000, 0, 1);
    chk("mrst_busy", rr_grt, 5'b10000);
    step(1, 5'b10001, 0, 1);
    chk("mrst_drop", rr_grt, 0);
    chk("mrst_vld", rr_vld, 0);
    chk("mrst_fp_drop", fp_grt, 0);
    step(0, 5'b10001, 0, 0);
    chk("mrst_ptr0", rr_grt, 5'b00001);
    chk("mrst_fp", fp_grt, 5'b00001);
    step(0, 5'b10001, 5'b00001, 1);
    step(0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", chks, errs);
    $finish;
  end
endmodule
